mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the CPU's data/instruction bus. Replaces the fixed-timing
//  memory model with a request/response slave that has programmable latency.
//  Accepts one word read or write per transaction. Returns read data, or a write
//  acknowledge, LATENCY cycles after acceptance. Storage is byte-addressed and big-endian.
// PARAMETERS
//  ADDR_W   8   byte-address bits implemented; depth = 2**ADDR_W bytes
//  LATENCY  2   cycles from request accept to rsp_valid; legal range 1..15
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   asynchronous reset, active-low (0 = reset)
//  req_valid   in   1   request present this cycle
//  req_write   in   1   1 = write, 0 = read
//  req_addr    in   32  byte address of the word
//  req_wdata   in   32  write data
//  req_ready   out  1   responder can accept a request this cycle
//  rsp_valid   out  1   one-cycle pulse: response/ack valid
//  rsp_rdata   out  32  read data; 0 for writes and on error
//  rsp_err     out  1   qualifies rsp_valid: misaligned or out-of-range access
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; req_ready=0 while rst=0; rsp_valid=0; rsp_rdata=0; rsp_err=0.
//   - Counter and captured request are cleared.
//   - Byte array is NOT cleared; contents survive reset.
//  FSM IDLE -> BUSY -> RESP -> IDLE:
//   - IDLE: req_ready=1. req_valid=1 at a rising edge captures write, addr and wdata,
//     loads cnt=LATENCY-1, then goes to BUSY (or to RESP directly if LATENCY=1).
//   - BUSY: req_ready=0; cnt decrements each cycle; at cnt==1 go to RESP.
//   - RESP: rsp_valid=1 for exactly this cycle; req_ready=0; next state is IDLE.
//   - Latency: accept edge N -> rsp_valid high during the cycle after edge N+LATENCY-1,
//     i.e. sampled at edge N+LATENCY.
//   - Throughput: one transaction per LATENCY+1 cycles. req_ready re-asserts the cycle after RESP.
//  Handshake:
//   - A transfer happens only when req_valid & req_ready.
//   - req_valid while req_ready=0 is ignored: no queuing, and the requester must re-present it.
//   - Request fields are sampled only at the accept edge; later changes have no effect.
//  Addressing:
//   - word = bytes A, A+1, A+2, A+3.
//   - rdata[31:24]=mem[A], [23:16]=mem[A+1], [15:8]=mem[A+2], [7:0]=mem[A+3].
//  Errors:
//   - Error condition: req_addr[1:0]!=0, or req_addr[31:ADDR_W]!=0.
//   - On error, RESP gives rsp_err=1 and rsp_rdata=0, with no memory update.
//   - Timing is unchanged on error.
//  Writes:
//   - Committed at the RESP-entry edge, all 4 bytes together.
//   - A read of the same word accepted afterwards returns the new data.
//  Read data: sampled from the array at the RESP-entry edge and registered; stable only while rsp_valid=1.
//  Reset mid-transaction: the transaction is aborted and no rsp_valid is produced.
//   - A write aborted before RESP entry is discarded.
//  rsp_rdata and rsp_err return to 0 in the cycle after RESP.
// TESTING
//  1. LATENCY=2: write 0xDEADBEEF @0x10, then read @0x10.
//     -> ack rsp_valid 2 cycles after accept, rsp_err=0; read returns 0xDEADBEEF.
//  2. Byte order: write 0x11223344 @0x20, then read 0x20.
//     -> mem[0x20]=0x11 and mem[0x23]=0x44 (via hierarchical peek); read returns 0x11223344.
//  3. Misaligned read @0x21 and out-of-range write @0x100 (ADDR_W=8).
//     -> rsp_err=1, rsp_rdata=0; the word at 0x20 is unchanged.
//  4. Hold req_valid=1 for 10 cycles with LATENCY=3.
//     -> accepts exactly every 4 cycles; req_ready=0 between accepts; one rsp_valid per accept.
//  5. Accept a write @0x30, then pull rst low 1 cycle later.
//     -> no rsp_valid; all outputs 0 immediately; a later read @0x30 returns its old value.
//  6. LATENCY=1: read @0x0.
//     -> rsp_valid on the cycle right after accept; req_ready back to 1 the following cycle.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: request/response memory slave with programmable latency.
// Accepts one 32-bit word read or write per transaction and answers LATENCY cycles
// after acceptance. Storage is byte-addressed and big-endian. Misaligned or
// out-of-range addresses get an error response with no memory update.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   req_valid  request present this cycle
//   req_write  1 = write, 0 = read
//   req_addr   byte address of the word
//   req_wdata  write data
//   req_ready  responder can accept a request this cycle
//   rsp_valid  one-cycle response/ack pulse
//   rsp_rdata  read data; 0 for writes and on error
//   rsp_err    qualifies rsp_valid: misaligned or out-of-range access
module mem_responder #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} stateE;

   localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

   stateE             stateQ, stateD;
   logic [3:0]        cntQ, cntD;
   logic              capWriteQ;
   logic [31:0]       capAddrQ;
   logic [31:0]       capWdataQ;
   logic [31:0]       rdataQ;
   logic              errQ;

   logic              accept;
   logic              respEntry;
   logic              effWrite;
   logic [31:0]       effAddr;
   logic [31:0]       effWdata;
   logic              effErr;
   logic [ADDR_W-1:0] idx;

   logic [7:0]        mem [2**ADDR_W];

   assign req_ready = (stateQ == StIdle) && rst;
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (stateQ == StResp);
   assign rsp_rdata = rdataQ;
   assign rsp_err   = errQ;

   // With LATENCY=1 the accept edge is also the RESP-entry edge, so the request
   // fields must be taken straight from the bus rather than from the capture regs.
   assign effWrite = (stateQ == StIdle) ? req_write : capWriteQ;
   assign effAddr  = (stateQ == StIdle) ? req_addr  : capAddrQ;
   assign effWdata = (stateQ == StIdle) ? req_wdata : capWdataQ;
   assign effErr   = (effAddr[1:0] != 2'b00) || ((effAddr >> ADDR_W) != 32'h0);
   assign idx      = effAddr[ADDR_W-1:0];

   assign respEntry = (stateD == StResp) && (stateQ != StResp);

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      unique case (stateQ)
         StIdle: begin
            if (accept) begin
               cntD   = CntLoad;
               stateD = (LATENCY == 1) ? StResp : StBusy;
            end
         end
         StBusy: begin
            cntD = cntQ - 4'd1;
            if (cntQ <= 4'd1) stateD = StResp;
         end
         StResp:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ    <= StIdle;
         cntQ      <= 4'd0;
         capWriteQ <= 1'b0;
         capAddrQ  <= 32'h0;
         capWdataQ <= 32'h0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         if (accept) begin
            capWriteQ <= req_write;
            capAddrQ  <= req_addr;
            capWdataQ <= req_wdata;
         end
      end
   end

   // Response registers: loaded on RESP entry, cleared on the way out of RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdataQ <= 32'h0;
         errQ   <= 1'b0;
      end else if (respEntry) begin
         errQ <= effErr;
         if (effErr || effWrite) begin
            rdataQ <= 32'h0;
         end else begin
            rdataQ <= {mem[idx], mem[{idx[ADDR_W-1:2], 2'd1}],
                       mem[{idx[ADDR_W-1:2], 2'd2}], mem[{idx[ADDR_W-1:2], 2'd3}]};
         end
      end else if (stateQ == StResp) begin
         rdataQ <= 32'h0;
         errQ   <= 1'b0;
      end
   end

   // Byte array has no reset: contents survive rst.
   always_ff @(posedge clk) begin
      if (respEntry && effWrite && !effErr) begin
         mem[idx]                      <= effWdata[31:24];
         mem[{idx[ADDR_W-1:2], 2'd1}] <= effWdata[23:16];
         mem[{idx[ADDR_W-1:2], 2'd2}] <= effWdata[15:8];
         mem[{idx[ADDR_W-1:2], 2'd3}] <= effWdata[7:0];
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (LATENCY 2, 3, 1) share the bus; sel picks
// which one sees req_valid. A byte-array model per instance predicts every response.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        reqValid;
   logic        reqWrite;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic [1:0]  sel;

   logic [2:0]  validV, readyV, rspValidV, errV;
   logic [31:0] rdataV [3];

   logic        readyS, rspValidS, errS;
   logic [31:0] rdataS;

   logic [7:0]  refMem [3][256];
   int          nVec = 0;
   int          nMis = 0;

   always #5 clk = ~clk;

   assign validV[0] = reqValid && (sel == 2'd0);
   assign validV[1] = reqValid && (sel == 2'd1);
   assign validV[2] = reqValid && (sel == 2'd2);
   assign readyS    = readyV[sel];
   assign rspValidS = rspValidV[sel];
   assign errS      = errV[sel];
   assign rdataS    = rdataV[sel];

   mem_responder #(.ADDR_W(8), .LATENCY(2)) uL2 (
      .clk(clk), .rst(rst), .req_valid(validV[0]), .req_write(reqWrite),
      .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(readyV[0]),
      .rsp_valid(rspValidV[0]), .rsp_rdata(rdataV[0]), .rsp_err(errV[0])
   );
   mem_responder #(.ADDR_W(8), .LATENCY(3)) uL3 (
      .clk(clk), .rst(rst), .req_valid(validV[1]), .req_write(reqWrite),
      .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(readyV[1]),
      .rsp_valid(rspValidV[1]), .rsp_rdata(rdataV[1]), .rsp_err(errV[1])
   );
   mem_responder #(.ADDR_W(8), .LATENCY(1)) uL1 (
      .clk(clk), .rst(rst), .req_valid(validV[2]), .req_write(reqWrite),
      .req_addr(reqAddr), .req_wdata(reqWdata), .req_ready(readyV[2]),
      .rsp_valid(rspValidV[2]), .rsp_rdata(rdataV[2]), .rsp_err(errV[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nMis++;
         $display("FAIL %s: got %h, expected %h (sel=%0d, t=%0t)", tag, got, exp, sel, $time);
      end
   endtask

   function automatic int latOf(input logic [1:0] s);
      case (s)
         2'd0:    return 2;
         2'd1:    return 3;
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] refWord(input logic [1:0] s, input logic [7:0] a);
      return {refMem[s][a], refMem[s][a + 8'd1], refMem[s][a + 8'd2], refMem[s][a + 8'd3]};
   endfunction

   // One full transaction on the selected instance. Entered and left at a negedge.
   task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] gotRdata);
      int          w;
      int          cyc;
      bit          err;
      logic [31:0] exp;
      gotRdata = 32'h0;
      w = 0;
      while (!readyS && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("reqReady", 32'(readyS), 32'd1);
      if (!readyS) return;
      reqValid = 1'b1;
      reqWrite = wr;
      reqAddr  = addr;
      reqWdata = wd;
      @(posedge clk);
      #1;
      // Scramble the bus: only accept-edge values may matter.
      reqValid = 1'b0;
      reqWrite = 1'($urandom);
      reqAddr  = $urandom;
      reqWdata = $urandom;
      err = (addr[1:0] != 2'b00) || (addr >= 32'd256);
      exp = 32'h0;
      if (!err && !wr) exp = refWord(sel, addr[7:0]);
      if (!err && wr) begin
         refMem[sel][addr[7:0]]         = wd[31:24];
         refMem[sel][addr[7:0] + 8'd1] = wd[23:16];
         refMem[sel][addr[7:0] + 8'd2] = wd[15:8];
         refMem[sel][addr[7:0] + 8'd3] = wd[7:0];
      end
      // Edges after the accept edge until rsp_valid is seen: LATENCY-1.
      cyc = 0;
      while (!rspValidS && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("latency", 32'(cyc), 32'(latOf(sel) - 1));
      check("rspErr", 32'(errS), 32'(err));
      check("rspRdata", rdataS, exp);
      gotRdata = rdataS;
      @(posedge clk);
      #1;
      check("rspPulse", 32'(rspValidS), 32'd0);
      check("rdataClr", rdataS, 32'h0);
      check("errClr", 32'(errS), 32'd0);
      check("readyBack", 32'(readyS), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      int          kind;
      rst      = 1'b0;
      reqValid = 1'b0;
      reqWrite = 1'b0;
      reqAddr  = 32'h0;
      reqWdata = 32'h0;
      sel      = 2'd0;

      // Reset state of every instance.
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         check("rstReady", 32'(readyS), 32'd0);
         check("rstValid", 32'(rspValidS), 32'd0);
         check("rstRdata", rdataS, 32'h0);
         check("rstErr", 32'(errS), 32'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Fill every word of every instance so the model knows all contents.
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         for (int w = 0; w < 64; w++) txn(1'b1, 32'(w * 4), $urandom, got);
      end

      // Basic write/read at LATENCY=2.
      sel = 2'd0;
      txn(1'b1, 32'h10, 32'hDEADBEEF, got);
      txn(1'b0, 32'h10, 32'h0, got);
      check("t1Read", got, 32'hDEADBEEF);

      // Big-endian byte order.
      txn(1'b1, 32'h20, 32'h11223344, got);
      check("peek20", 32'(uL2.mem[32]), 32'h11);
      check("peek23", 32'(uL2.mem[35]), 32'h44);
      txn(1'b0, 32'h20, 32'h0, got);
      check("t2Read", got, 32'h11223344);

      // Error accesses leave memory alone.
      txn(1'b0, 32'h21, 32'h0, got);
      txn(1'b1, 32'h100, 32'hFFFFFFFF, got);
      txn(1'b1, 32'h22, 32'hFFFFFFFF, got);
      txn(1'b0, 32'h20, 32'h0, got);
      check("t3Intact", got, 32'h11223344);

      // Back-to-back held request at LATENCY=3: accept every 4 cycles.
      sel      = 2'd1;
      reqValid = 1'b1;
      reqWrite = 1'b0;
      reqAddr  = 32'h10;
      for (int c = 0; c < 16; c++) begin
         #1;
         check("holdReady", 32'(readyS), 32'((c % 4) == 0));
         check("holdRsp", 32'(rspValidS), 32'((c % 4) == 3));
         if ((c % 4) == 3) check("holdRdata", rdataS, refWord(2'd1, 8'h10));
         @(negedge clk);
      end
      reqValid = 1'b0;
      @(negedge clk);

      // Reset one cycle after accepting a write: write must be dropped.
      reqValid = 1'b1;
      reqWrite = 1'b1;
      reqAddr  = 32'h30;
      reqWdata = ~refWord(2'd1, 8'h30);
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abortReady", 32'(readyS), 32'd0);
      check("abortValid", 32'(rspValidS), 32'd0);
      check("abortRdata", rdataS, 32'h0);
      check("abortErr", 32'(errS), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("abortNoRsp", 32'(rspValidS), 32'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("abortNoRsp2", 32'(rspValidS), 32'd0);
      end
      @(negedge clk);
      txn(1'b0, 32'h30, 32'h0, got);

      // LATENCY=1 read.
      sel = 2'd2;
      txn(1'b0, 32'h0, 32'h0, got);

      // Randomized mix across all instances.
      for (int i = 0; i < 90; i++) begin
         sel  = 2'($urandom_range(0, 2));
         kind = int'($urandom_range(0, 9));
         if (kind == 0) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
         else if (kind == 1) a = ($urandom & 32'hFFFF_FF00) | 32'h100;
         else a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         txn(1'($urandom), a, $urandom, got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
